// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared constants and types for the microcoded Y86-64 core's data-memory
// responder.
//   Y86_WORD_WIDTH   width of a Y86-64 data word (64)
//   DM_WORD_BYTES    bytes moved per data-memory access (8)
//   DM_IDLE..DM_ERR  state encodings of the responder FSM
//   dmState_t        enum built on those encodings
//   dmOp_t           latched operation kind (read / write)
//   dmAddrInRange    true when a whole word starting at addr fits in the RAM
// ---------------------------------------------------------------------------
package y86_pkg;

   localparam int Y86_WORD_WIDTH = 64;
   localparam int DM_WORD_BYTES  = 8;

   localparam logic [2:0] DM_IDLE   = 3'd0;
   localparam logic [2:0] DM_ACCESS = 3'd1;
   localparam logic [2:0] DM_DRAIN  = 3'd2;
   localparam logic [2:0] DM_DONE   = 3'd3;
   localparam logic [2:0] DM_ERR    = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = DM_IDLE,
      ST_ACCESS = DM_ACCESS,
      ST_DRAIN  = DM_DRAIN,
      ST_DONE   = DM_DONE,
      ST_ERR    = DM_ERR
   } dmState_t;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } dmOp_t;

   // A word is legal only if every one of its bytes lands inside the RAM.
   // Comparing the full 64-bit address against the last legal start address
   // rejects both set upper bits and words that would run off the top.
   function automatic logic dmAddrInRange(input logic [63:0] addr,
                                          input int          addrWidth,
                                          input int          wordBytes);
      logic [63:0] limit;
      limit = (64'd1 << addrWidth) - 64'(wordBytes);
      return (addr <= limit);
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the Y86-64 datapath (master) and the data
// memory responder (slave).
//   dmemRead    master->slave  read request level
//   dmemWrite   master->slave  write request level
//   dmemAddr    master->slave  byte address (valE)
//   dmemWData   master->slave  write data (valA)
//   dmemRData   slave->master  read result, held between reads
//   DMemReady   slave->master  one-cycle completion pulse
//   dmemError   slave->master  request rejected, qualified by DMemReady
//   dmemBusy    slave->master  responder is not idle
// ---------------------------------------------------------------------------
interface dmem_responder_if;
   import y86_pkg::*;

   logic                      dmemRead;
   logic                      dmemWrite;
   logic [Y86_WORD_WIDTH-1:0] dmemAddr;
   logic [Y86_WORD_WIDTH-1:0] dmemWData;
   logic [Y86_WORD_WIDTH-1:0] dmemRData;
   logic                      DMemReady;
   logic                      dmemError;
   logic                      dmemBusy;

   modport master (
      output dmemRead, dmemWrite, dmemAddr, dmemWData,
      input  dmemRData, DMemReady, dmemError, dmemBusy
   );

   modport slave (
      input  dmemRead, dmemWrite, dmemAddr, dmemWData,
      output dmemRData, DMemReady, dmemError, dmemBusy
   );

endinterface

// File: rtl/dmem_byte_ram.sv
// ---------------------------------------------------------------------------
// dmem_byte_ram
// Single-port byte-wide RAM with synchronous read. The responder never reads
// and writes the same byte in one cycle, so read-during-write ordering does
// not matter. Contents are not reset.
//   i_clk     clock
//   i_we      write enable for this cycle
//   i_addr    byte address
//   i_wdata   byte to write
//   o_rdata   byte at the previous cycle's address
// ---------------------------------------------------------------------------
module dmem_byte_ram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [7:0]            i_wdata,
   output logic [7:0]            o_rdata
);

   logic [7:0] r_mem [2**ADDR_WIDTH];
   logic [7:0] r_rdata;

   // Storage array and registered read port. The read is issued every cycle;
   // the responder only consumes the result while a read is in flight.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Far end of the DMemReady handshake of the microcoded Y86-64 core. Takes one
// 64-bit read or write, performs it as WORD_BYTES little-endian byte accesses
// to a byte RAM, then pulses DMemReady for one cycle. One request at a time.
//   clk       clock, all state changes on the rising edge
//   rst_n     asynchronous active-low reset (RAM contents survive)
//   io_dmem   request/response bundle (slave side), see dmem_responder_if
// Latency: request sampled on edge 0, DMemReady high in cycle WORD_BYTES+2;
// a rejected request answers in cycle 1 with dmemError.
// ---------------------------------------------------------------------------
module dmem_responder
   import y86_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int WORD_BYTES = DM_WORD_BYTES
) (
   input  logic             clk,
   input  logic             rst_n,
   dmem_responder_if.slave  io_dmem
);

   localparam int IDX_W = $clog2(WORD_BYTES);

   dmState_t                  r_state;
   dmState_t                  w_nextState;
   logic                      w_accept;

   dmOp_t                     r_op;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [Y86_WORD_WIDTH-1:0] r_wdata;
   logic [IDX_W-1:0]          r_index;
   logic [Y86_WORD_WIDTH-1:0] r_assembly;
   logic [Y86_WORD_WIDTH-1:0] r_rData;

   logic                      w_addrOk;
   logic                      w_oneReq;
   logic                      w_bothReq;
   logic [ADDR_WIDTH-1:0]     w_ramAddr;
   logic                      w_ramWe;
   logic [7:0]                w_ramWData;
   logic [7:0]                w_ramRData;
   logic                      w_capture;
   logic [IDX_W-1:0]          w_lane;

   assign w_addrOk  = dmAddrInRange(io_dmem.dmemAddr, ADDR_WIDTH, WORD_BYTES);
   assign w_oneReq  = io_dmem.dmemRead ^ io_dmem.dmemWrite;
   assign w_bothReq = io_dmem.dmemRead & io_dmem.dmemWrite;

   // State register; reset aborts any access in flight without a pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake outputs. Requests are only looked at in IDLE,
   // so a level still held after DONE starts a fresh operation one cycle
   // later. During DONE of a read the freshly assembled word is shown
   // directly so the datapath sees it in the same cycle as DMemReady.
   always_comb begin
      w_nextState       = r_state;
      w_accept          = 1'b0;
      io_dmem.DMemReady = 1'b0;
      io_dmem.dmemError = 1'b0;
      io_dmem.dmemBusy  = (r_state != ST_IDLE);
      io_dmem.dmemRData = r_rData;
      case (r_state)
         ST_IDLE: begin
            if (w_bothReq) begin
               w_nextState = ST_ERR;
            end else if (w_oneReq) begin
               if (w_addrOk) begin
                  w_accept    = 1'b1;
                  w_nextState = ST_ACCESS;
               end else begin
                  w_nextState = ST_ERR;
               end
            end
         end
         ST_ACCESS: begin
            if (r_index == IDX_W'(WORD_BYTES - 1)) begin
               w_nextState = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_nextState = ST_DONE;
         end
         ST_DONE: begin
            io_dmem.DMemReady = 1'b1;
            if (r_op == OP_READ) begin
               io_dmem.dmemRData = r_assembly;
            end
            w_nextState = ST_IDLE;
         end
         ST_ERR: begin
            io_dmem.DMemReady = 1'b1;
            io_dmem.dmemError = 1'b1;
            w_nextState       = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Request latches and byte index. Address and data are captured only on
   // accept, so anything the datapath does to them afterwards is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op    <= OP_READ;
         r_addr  <= '0;
         r_wdata <= '0;
         r_index <= '0;
      end else begin
         if (w_accept) begin
            r_op    <= io_dmem.dmemWrite ? OP_WRITE : OP_READ;
            r_addr  <= io_dmem.dmemAddr[ADDR_WIDTH-1:0];
            r_wdata <= io_dmem.dmemWData;
            r_index <= '0;
         end else if (r_state == ST_ACCESS) begin
            r_index <= r_index + IDX_W'(1);
         end
      end
   end

   // RAM port drive: one byte per ACCESS cycle, little-endian lanes.
   always_comb begin
      w_ramAddr  = r_addr + ADDR_WIDTH'(r_index);
      w_ramWe    = (r_state == ST_ACCESS) && (r_op == OP_WRITE);
      w_ramWData = r_wdata[8*r_index +: 8];
   end

   // Read data comes back one cycle after its address, so the byte arriving
   // while index is i belongs to lane i-1; the last lane arrives in DRAIN.
   always_comb begin
      w_capture = (r_op == OP_READ) &&
                  (((r_state == ST_ACCESS) && (r_index != '0)) ||
                   (r_state == ST_DRAIN));
      w_lane    = (r_state == ST_DRAIN) ? IDX_W'(WORD_BYTES - 1)
                                        : r_index - IDX_W'(1);
   end

   // Assembly register and held read result. dmemRData only changes when a
   // read completes; writes and rejected requests leave it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_assembly <= '0;
         r_rData    <= '0;
      end else begin
         if (w_capture) begin
            r_assembly[8*w_lane +: 8] <= w_ramRData;
         end
         if ((r_state == ST_DONE) && (r_op == OP_READ)) begin
            r_rData <= r_assembly;
         end
      end
   end

   dmem_byte_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .i_clk   (clk),
      .i_we    (w_ramWe),
      .i_addr  (w_ramAddr),
      .i_wdata (w_ramWData),
      .o_rdata (w_ramRData)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Scoreboard bench for dmem_responder: every accepted or rejected request
// pushes its expected completion (cycle, error flag, read data) and a
// monitor pops and compares on each DMemReady pulse. A byte model of the RAM
// supplies read expectations; bytes never written are masked out.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int AW        = 10;
   localparam int RAM_BYTES = 2**AW;
   localparam logic [63:0] LAST_OK = 64'(RAM_BYTES - 8);

   typedef struct {
      logic        err;
      logic [63:0] data;
      logic [63:0] mask;
      int          readyCycle;
   } expect_t;

   logic clk;
   logic rst_n;
   int   cycleCount;
   int   compareCount;
   int   failCount;

   expect_t     sbQueue[$];
   logic [7:0]  modelMem   [RAM_BYTES];
   bit          modelKnown [RAM_BYTES];
   logic [63:0] modelRData;
   logic [63:0] modelRMask;

   dmem_responder_if dmemIf();

   dmem_responder #(
      .ADDR_WIDTH (AW),
      .WORD_BYTES (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .io_dmem (dmemIf.slave)
   );

   // Free-running clock and edge counter used to time every completion.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycleCount = 0;
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
      end
   endtask

   // Scoreboard monitor: each DMemReady pulse consumes the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && dmemIf.DMemReady === 1'b1) begin
         if (sbQueue.size() == 0) begin
            checkOutput("spuriousReady", 64'd1, 64'd0);
         end else begin
            expect_t e;
            e = sbQueue.pop_front();
            checkOutput("readyCycle", 64'(cycleCount), 64'(e.readyCycle));
            checkOutput("dmemError", 64'(dmemIf.dmemError), 64'(e.err));
            checkOutput("dmemRData", dmemIf.dmemRData & e.mask, e.data & e.mask);
         end
      end
   end

   // Model the effect of a request sampled on the edge that set cycleCount to
   // c0, and queue its expected completion.
   task automatic expectOp(input logic rd, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input int c0);
      expect_t e;
      bit      err;
      int      idx;
      err = (rd && wr) || (addr > LAST_OK);
      if (!err && wr) begin
         for (int i = 0; i < 8; i++) begin
            idx = int'(addr[AW-1:0]) + i;
            modelMem[idx]   = wdata[8*i +: 8];
            modelKnown[idx] = 1'b1;
         end
      end
      if (!err && rd) begin
         for (int i = 0; i < 8; i++) begin
            idx = int'(addr[AW-1:0]) + i;
            modelRData[8*i +: 8] = modelMem[idx];
            modelRMask[8*i +: 8] = modelKnown[idx] ? 8'hFF : 8'h00;
         end
      end
      e.err        = err;
      e.readyCycle = err ? c0 : c0 + 9;
      e.data       = modelRData;
      e.mask       = modelRMask;
      sbQueue.push_back(e);
   endtask

   // Wait (bounded) for the scoreboard to drain.
   task automatic waitIdle();
      for (int i = 0; i < 40 && sbQueue.size() != 0; i++) @(negedge clk);
      if (sbQueue.size() != 0) begin
         checkOutput("readyTimeout", 64'(sbQueue.size()), 64'd0);
         sbQueue.delete();
      end
      @(negedge clk);
   endtask

   // Present one request for a single sampling edge, optionally scrambling
   // address/data (with write held) while the operation runs.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [63:0] addr,
                                input logic [63:0] wdata, input bit scramble);
      int c0;
      @(negedge clk);
      dmemIf.dmemRead  = rd;
      dmemIf.dmemWrite = wr;
      dmemIf.dmemAddr  = addr;
      dmemIf.dmemWData = wdata;
      @(posedge clk);
      #1;
      c0 = cycleCount;
      expectOp(rd, wr, addr, wdata, c0);
      if (scramble) begin
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dmemIf.dmemAddr  = 64'($urandom_range(0, RAM_BYTES - 8));
            dmemIf.dmemWData = {$urandom(), $urandom()};
         end
      end
      dmemIf.dmemRead  = 1'b0;
      dmemIf.dmemWrite = 1'b0;
      waitIdle();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int c0;
      bit sawPulse;
      compareCount     = 0;
      failCount        = 0;
      modelRData       = '0;
      modelRMask       = '1;
      dmemIf.dmemRead  = 1'b0;
      dmemIf.dmemWrite = 1'b0;
      dmemIf.dmemAddr  = '0;
      dmemIf.dmemWData = '0;
      for (int i = 0; i < RAM_BYTES; i++) modelKnown[i] = 1'b0;

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetReady", 64'(dmemIf.DMemReady), 64'd0);
      checkOutput("resetError", 64'(dmemIf.dmemError), 64'd0);
      checkOutput("resetBusy", 64'(dmemIf.dmemBusy), 64'd0);
      checkOutput("resetRData", dmemIf.dmemRData, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] write 0x0123456789ABCDEF to 0x010, busy profile");
      fork
         applyStimulus(1'b0, 1'b1, 64'h10, 64'h0123456789ABCDEF, 1'b0);
         begin
            @(negedge clk);
            @(posedge clk);
            #1;
            for (int k = 1; k <= 9; k++) begin
               @(negedge clk);
               checkOutput("busyDuringOp", 64'(dmemIf.dmemBusy), 64'd1);
            end
            @(negedge clk);
            @(negedge clk);
            checkOutput("idleAfterDone", 64'(dmemIf.dmemBusy), 64'd0);
         end
      join

      $display("[TB] aligned and unaligned read-back");
      applyStimulus(1'b1, 1'b0, 64'h10, 64'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 64'h11, 64'h0, 1'b0);

      $display("[TB] highest legal word, then rejected requests");
      applyStimulus(1'b0, 1'b1, LAST_OK, 64'hFEDCBA9876543210, 1'b0);
      applyStimulus(1'b1, 1'b0, LAST_OK, 64'h0, 1'b0);
      applyStimulus(1'b1, 1'b1, 64'h10, 64'hDEADBEEFDEADBEEF, 1'b0);
      applyStimulus(1'b0, 1'b1, LAST_OK + 64'd1, 64'h5555555555555555, 1'b0);
      applyStimulus(1'b0, 1'b1, (64'd1 << 40) | 64'h10, 64'hAAAAAAAAAAAAAAAA, 1'b0);
      applyStimulus(1'b1, 1'b0, LAST_OK, 64'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 64'h10, 64'h0, 1'b0);

      $display("[TB] inputs scrambled during a write");
      applyStimulus(1'b0, 1'b1, 64'h40, 64'h1122334455667788, 1'b1);
      applyStimulus(1'b1, 1'b0, 64'h40, 64'h0, 1'b0);

      $display("[TB] reset in cycle 4 of a write");
      applyStimulus(1'b0, 1'b1, 64'h80, 64'h1111111111111111, 1'b0);
      @(negedge clk);
      dmemIf.dmemWrite = 1'b1;
      dmemIf.dmemAddr  = 64'h80;
      dmemIf.dmemWData = 64'hAABBCCDDEEFF0011;
      @(posedge clk);
      #1;
      c0 = cycleCount;
      dmemIf.dmemWrite = 1'b0;
      while (cycleCount != c0 + 3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abortReady", 64'(dmemIf.DMemReady), 64'd0);
      checkOutput("abortError", 64'(dmemIf.dmemError), 64'd0);
      checkOutput("abortBusy", 64'(dmemIf.dmemBusy), 64'd0);
      checkOutput("abortRData", dmemIf.dmemRData, 64'd0);
      modelRData = '0;
      modelRMask = '1;
      modelMem[16'h80] = 8'h11;
      modelMem[16'h81] = 8'h00;
      modelMem[16'h82] = 8'hFF;
      modelKnown[16'h83] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sawPulse = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         sawPulse = sawPulse | (dmemIf.DMemReady === 1'b1);
      end
      checkOutput("noPulseAfterAbort", 64'(sawPulse), 64'd0);
      applyStimulus(1'b1, 1'b0, 64'h80, 64'h0, 1'b0);

      $display("[TB] back-to-back write then read, levels held");
      @(negedge clk);
      dmemIf.dmemWrite = 1'b1;
      dmemIf.dmemAddr  = 64'h100;
      dmemIf.dmemWData = 64'hC0FFEE0012345678;
      @(posedge clk);
      #1;
      c0 = cycleCount;
      expectOp(1'b0, 1'b1, 64'h100, 64'hC0FFEE0012345678, c0);
      expectOp(1'b1, 1'b0, 64'h100, 64'h0, c0 + 11);
      while (cycleCount != c0 + 9) @(negedge clk);
      dmemIf.dmemWrite = 1'b0;
      dmemIf.dmemRead  = 1'b1;
      while (cycleCount != c0 + 20) @(negedge clk);
      dmemIf.dmemRead  = 1'b0;
      waitIdle();

      $display("End of test - %0d assertions evaluated, %0d failures", compareCount, failCount);
      $finish;
   end

endmodule
